// File: rtl/multicycle_control.sv
`default_nettype none
// multicycle_control: control FSM for a multicycle MIPS-subset datapath (R-type, lw, sw, beq, j).
// Rev 1.0 -- initial release.
module multicycle_control #(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                IRWrite,
  output logic                ALUSrcA,
  output logic                RegWrite,
  output logic                RegDst,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSource,
  output logic [2:0]          ALUOp,
  output logic [3:0]          state,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  localparam logic [RETIRE_W-1:0] RETIRE_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                retire;
  logic                op_valid;
  logic                funct_valid;
  logic [2:0]          funct_aluop;

  always_comb begin
    op_valid = 1'b1;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_valid = 1'b1;
      default:                              op_valid = 1'b0;
    endcase

    funct_valid = 1'b1;
    funct_aluop = ALU_ADD;
    case (funct)
      6'b100000: funct_aluop = ALU_ADD;
      6'b100010: funct_aluop = ALU_SUB;
      6'b100100: funct_aluop = ALU_AND;
      6'b100101: funct_aluop = ALU_OR;
      6'b100110: funct_aluop = ALU_XOR;
      default:   funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC:   state_d = funct_valid ? S_RWB : S_FETCH;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:  state_d = S_FETCH;
    endcase
    retired_d = retire ? retired_q + RETIRE_ONE : retired_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Strobes are held low while reset is asserted so an aborted instruction cannot write anything.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = ALU_ADD;
    illegal     = 1'b0;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          illegal = ~op_valid;
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = funct_aluop;
          illegal = ~funct_valid;
        end
        S_RWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// tb_multicycle_control: table vectors, reset/wrap sequences and random instructions vs a reference model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic       ALUSrcA, RegWrite, RegDst, illegal;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] state;
  logic [3:0] retired;
  logic [17:0] ctrl_vec;

  int nvec = 0;
  int nerr = 0;
  int ret_m = 0;

  multicycle_control #(.RETIRE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .state(state), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  assign ctrl_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                     ALUSrcA, RegWrite, RegDst, ALUSrcB, PCSource, ALUOp, illegal};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit funct_ok(input logic [5:0] fn);
    return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26};
  endfunction

  function automatic bit op_ok(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02};
  endfunction

  // Expected strobe vector for one cycle, straight from the per-state output table.
  function automatic logic [17:0] exp_ctrl(input int st, input bit mr, input logic [5:0] op,
                                           input logic [5:0] fn);
    logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0, irw = 0;
    logic asa = 0, rw = 0, rd = 0, ill = 0;
    logic [1:0] asb = 0, pcs = 0;
    logic [2:0] aop = 0;
    case (st)
      0: begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1: begin asb = 2'b11; ill = !op_ok(op); end
      2: begin asa = 1; asb = 2'b10; end
      3: begin mrd = 1; iord = 1; end
      4: begin m2r = 1; rw = 1; end
      5: begin mwr = 1; iord = 1; end
      6: begin
        asa = 1;
        case (fn)
          6'h20: aop = 3'd0;
          6'h22: aop = 3'd1;
          6'h24: aop = 3'd2;
          6'h25: aop = 3'd3;
          6'h26: aop = 3'd4;
          default: ill = 1;
        endcase
      end
      7: begin rd = 1; rw = 1; end
      8: begin asa = 1; aop = 3'd1; pcwc = 1; pcs = 2'b01; end
      9: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, asb, pcs, aop, ill};
  endfunction

  // Model: build the expected state trace for one instruction, then walk it cycle by cycle.
  // Call at #1 after a rising edge with the DUT in FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    int q[$];
    int ret = 0;
    int memcnt = 0;
    bit mr;
    for (int i = 0; i <= fw; i++) q.push_back(0);
    q.push_back(1);
    if (op == 6'h00) begin
      q.push_back(6);
      if (funct_ok(fn)) begin q.push_back(7); ret = 1; end
    end else if (op == 6'h23 || op == 6'h2B) begin
      q.push_back(2);
      repeat (mw + 1) q.push_back(op == 6'h23 ? 3 : 5);
      if (op == 6'h23) q.push_back(4);
      ret = 1;
    end else if (op == 6'h04) begin
      q.push_back(8); ret = 1;
    end else if (op == 6'h02) begin
      q.push_back(9); ret = 1;
    end
    foreach (q[i]) begin
      mr = 1'b1;
      if (q[i] == 0) mr = (i == fw);
      if (q[i] == 3 || q[i] == 5) begin mr = (memcnt == mw); memcnt++; end
      mem_ready = mr;
      if (q[i] == 1 || q[i] == 2 || q[i] == 6) begin
        opcode = op; funct = fn;
      end else begin
        opcode = 6'($urandom); funct = 6'($urandom);
      end
      @(negedge clk);
      chk("rnd_state", 32'(state), 32'(q[i]));
      chk("rnd_ctrl", 32'(ctrl_vec), 32'(exp_ctrl(q[i], mr, op, fn)));
      @(posedge clk); #1;
    end
    ret_m = (ret_m + ret) % 16;
    chk("rnd_retired", 32'(retired), 32'(ret_m));
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int fw;
    int mw;
    int len;
    int ills;
    int ret;
  } vec_t;

  // Apply one table vector, measuring cycle count and illegal pulses on the DUT.
  task automatic table_run(input vec_t v);
    int cyc = 0, ills = 0, wf = v.fw, wm = v.mw;
    bit left = 0, done = 0;
    opcode = v.op; funct = v.fn;
    for (int k = 0; k < 30 && !done; k++) begin
      mem_ready = 1'b1;
      if (state == 4'd0 && wf > 0) begin mem_ready = 1'b0; wf--; end
      if ((state == 4'd3 || state == 4'd5) && wm > 0) begin mem_ready = 1'b0; wm--; end
      @(negedge clk);
      cyc++;
      ills += int'(illegal);
      if (state != 4'd0) left = 1;
      @(posedge clk); #1;
      if (left && state == 4'd0) done = 1;
    end
    chk("tbl_done", 32'(done), 32'd1);
    chk("tbl_cycles", 32'(cyc), 32'(v.len));
    chk("tbl_illegal", 32'(ills), 32'(v.ills));
    ret_m = (ret_m + v.ret) % 16;
    chk("tbl_retired", 32'(retired), 32'(ret_m));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    logic [5:0] op, fn;
    int kind;
    tbl[0] = '{6'h00, 6'h22, 0, 0, 4, 0, 1};
    tbl[1] = '{6'h00, 6'h20, 1, 0, 5, 0, 1};
    tbl[2] = '{6'h23, 6'h00, 0, 2, 7, 0, 1};
    tbl[3] = '{6'h23, 6'h15, 0, 0, 5, 0, 1};
    tbl[4] = '{6'h2B, 6'h00, 0, 0, 4, 0, 1};
    tbl[5] = '{6'h2B, 6'h3F, 2, 1, 7, 0, 1};
    tbl[6] = '{6'h04, 6'h00, 0, 0, 3, 0, 1};
    tbl[7] = '{6'h02, 6'h00, 0, 0, 3, 0, 1};
    tbl[8] = '{6'h3F, 6'h20, 0, 0, 2, 1, 0};
    tbl[9] = '{6'h00, 6'h07, 0, 0, 3, 1, 0};

    reset = 1'b0; mem_ready = 1'b0; opcode = 6'h00; funct = 6'h00;
    #3;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_retired", 32'(retired), 32'd0);
    chk("reset_ctrl", 32'(ctrl_vec), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("release_ctrl", 32'(ctrl_vec), 32'(exp_ctrl(0, 1'b0, 6'h00, 6'h00)));

    foreach (tbl[i]) table_run(tbl[i]);

    // sw stalled in MEMWR, reset asserted between clock edges
    opcode = 6'h2B; funct = 6'h00; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("mid_state", 32'(state), 32'd5);
    chk("mid_memwrite", 32'(MemWrite), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_memwrite", 32'(MemWrite), 32'd0);
    chk("abort_ctrl", 32'(ctrl_vec), 32'd0);
    chk("abort_retired", 32'(retired), 32'd0);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    chk("abort_hold_state", 32'(state), 32'd0);
    chk("abort_hold_ctrl", 32'(ctrl_vec), 32'd0);
    mem_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rerelease_ctrl", 32'(ctrl_vec), 32'(exp_ctrl(0, 1'b0, 6'h00, 6'h00)));
    ret_m = 0;
    @(posedge clk); #1;
    chk("rerelease_state", 32'(state), 32'd0);

    // 16 retirements on a 4-bit counter return it to zero
    for (int i = 0; i < 16; i++) run_instr(6'h02, 6'($urandom), 0, 0);
    chk("wrap_zero", 32'(retired), 32'd0);

    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 7));
      op = 6'h00;
      fn = 6'h20;
      case (kind)
        0, 7: begin
          op = 6'h00;
          case ($urandom_range(0, 4))
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h24;
            3: fn = 6'h25;
            default: fn = 6'h26;
          endcase
        end
        1: begin
          op = 6'h00;
          do fn = 6'($urandom); while (funct_ok(fn));
        end
        2: op = 6'h23;
        3: op = 6'h2B;
        4: op = 6'h04;
        5: op = 6'h02;
        default: do op = 6'($urandom); while (op_ok(op));
      endcase
      if (kind >= 2 && kind <= 6) fn = 6'($urandom);
      run_instr(op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: RETIRE_W, default 16, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces the reset state immediately, independent of clk.
REQ-004 opcode  input  6  instruction[31:26] from the datapath instruction register.
REQ-005 funct  input  6  instruction[5:0] from the instruction register.
REQ-006 mem_ready  input  1  memory handshake; 1 = current read/write completes this cycle.
REQ-007 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath strobes/selects.
REQ-008 ALUSrcB  output  2  00=reg B, 01=constant 1 (word-addressed PC), 10=sign-ext imm, 11=sign-ext imm (branch offset).
REQ-009 PCSource  output  2  00=ALU result, 01=ALUOut register, 10=jump target {PC[31:26],instr[25:0]}.
REQ-010 ALUOp  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor.
REQ-011 state  output  4  current FSM state encoding (debug).
REQ-012 illegal  output  1  one-cycle pulse on an unsupported opcode/funct.
REQ-013 retired  output  RETIRE_W  count of completed instructions.

Function
REQ-014 FSM states (encoding): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9; codes 10-15 unreachable; if entered, next state is FETCH.
REQ-015 Every output not listed for a state is 0 in that state.
REQ-016 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00; IRWrite=PCWrite=mem_ready (combinational); stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-017 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target into ALUOut); next by opcode: 000000->EXEC, 100011 or 101011->MEMADR, 000100->BRANCH, 000010->JUMP, any other -> FETCH with illegal=1.
REQ-018 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp from funct: 100000->000, 100010->001, 100100->010, 100101->011, 100110->100; valid funct -> RWB; any other funct -> FETCH with illegal=1, ALUOp=000, no writeback.
REQ-019 RWB: RegDst=1, MemtoReg=0, RegWrite=1; next FETCH; retired increments.
REQ-020 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000; next MEMRD if opcode=100011, MEMWR if 101011.
REQ-021 MEMRD: MemRead=1, IorD=1; hold while mem_ready=0; MEMWB when mem_ready=1.
REQ-022 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH; retired increments.
REQ-023 MEMWR: MemWrite=1, IorD=1; hold while mem_ready=0; when mem_ready=1 -> FETCH, retired increments.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01; next FETCH; retired increments (taken or not).
REQ-025 JUMP: PCWrite=1, PCSource=10; next FETCH; retired increments.
REQ-026 CPI: R-type 4, beq 3, j 3, sw 4, lw 5 cycles, each plus one cycle per mem_ready=0 wait.
REQ-027 retired wraps from all-ones to 0 with no flag; illegal instructions do not increment it.
REQ-028 illegal is asserted only in the DECODE or EXEC cycle that detects the fault.
REQ-029 opcode/funct are sampled only in DECODE, EXEC and MEMADR; changes in other states have no effect.

Reset
REQ-030 reset=0 asynchronously sets state=FETCH, retired=0, and all registered outputs to 0; outputs take FETCH values (MemRead=1) once reset=1.
REQ-031 Assertion mid-instruction (any state, including a memory wait) aborts it: no RegWrite, MemWrite or PC update occurs after reset falls, and retired is not incremented.
REQ-032 The first rising clk edge with reset=1 evaluates FETCH transitions normally.

Verification
REQ-033 mem_ready=1, opcode=000000, funct=100010 -> states 0,1,6,7; ALUOp=001 in EXEC; RegWrite=1, RegDst=1 in RWB; retired 0->1.
REQ-034 lw (100011), mem_ready=0 for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4 (7 cycles); MemtoReg=1, RegWrite=1 in MEMWB.
REQ-035 sw (101011) -> MemWrite=1 only in MEMWR; RegWrite=0 throughout; 4 cycles.
REQ-036 opcode=111111 -> illegal=1 in DECODE, next state FETCH, retired unchanged; R-type funct=000111 -> illegal=1 in EXEC, no RegWrite.
REQ-037 beq -> PCWriteCond=1, PCSource=01, ALUOp=001 in BRANCH; j -> PCWrite=1, PCSource=10; each 3 cycles.
REQ-038 reset=0 between edges during MEMWR wait -> state=0 immediately, MemWrite=0, retired=0; RETIRE_W=4 with 16 retired instructions -> retired wraps to 0.
